elastic_delay: RTL
==================

ELASTIC_DELAY -- requirements
Module: elastic_delay

Interface
REQ-001 SHALL have parameter WIDTH, default 1, data word width in bits (>= 1).
REQ-002 SHALL have parameter DELAY, default 1, number of pipeline stages and unstalled latency in cycles (>= 1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port din_valid  input  1  producer presents a word on din.
REQ-006 SHALL have port din_ready  output  1  block accepts din this cycle.
REQ-007 SHALL have port din  input  WIDTH  input word.
REQ-008 SHALL have port dout_valid  output  1  word on dout is valid.
REQ-009 SHALL have port dout_ready  input  1  consumer takes dout this cycle.
REQ-010 SHALL have port dout  output  WIDTH  output word.

Function
REQ-011 SHALL implement DELAY stages, each holding a valid bit and a WIDTH-bit data register; stage 1 fed from din, stage DELAY drives dout/dout_valid directly from registers.
REQ-012 SHALL count a transfer on the input side when din_valid && din_ready, and on the output side when dout_valid && dout_ready, sampled at the rising edge.
REQ-013 SHALL let stage k accept when it is empty or its content leaves the same cycle; stage DELAY leaves on dout_ready; stage k<DELAY leaves when stage k+1 accepts.
REQ-014 SHALL drive din_ready = acceptance condition of stage 1 (combinational path from dout_ready through the chain permitted; bubbles collapse).
REQ-015 SHALL present a word accepted at edge t on dout with dout_valid=1 after edge t+DELAY-1 (first visible in cycle t+DELAY) when dout_ready stays high.
REQ-016 SHALL sustain one transfer per cycle in both directions when din_valid and dout_ready stay high.
REQ-017 SHALL hold up to DELAY words; with all stages valid and dout_ready=0, din_ready SHALL be 0.
REQ-018 SHALL preserve word order; no word is dropped, duplicated or reordered.
REQ-019 SHALL keep dout and dout_valid stable while dout_valid=1 and dout_ready=0.
REQ-020 SHALL, on a full pipeline with dout_ready=1 and din_valid=1, accept the new word and emit the oldest in the same cycle.
REQ-021 SHALL leave a data register unchanged when its stage does not accept; dout content is don't-care when dout_valid=0.
REQ-022 SHALL ignore din when din_valid=0; an empty stage advancing receives valid=0.

Reset
REQ-023 SHALL, when rst=1 at a rising edge, clear all stage valid bits and all data registers to 0, regardless of pending transfers.
REQ-024 SHALL drive dout_valid=0, dout=0 and din_ready=1 in the cycle after reset; a transfer presented in the reset cycle is discarded.
REQ-025 SHALL take reset priority over every simultaneous input or output transfer.

Configuration
REQ-026 SHALL, when macro ELASTIC_DELAY_COUNT_EN is defined, add output port count (width clog2(DELAY+1)) equal to the number of valid stages, registered, reset to 0.
REQ-027 SHALL update count by +1 on input-only transfer, -1 on output-only transfer, unchanged on both or neither.
REQ-028 SHALL, without ELASTIC_DELAY_COUNT_EN, omit port count and its logic with otherwise identical behaviour.

Verification (WIDTH=8, DELAY=3)
REQ-029 SHALL cover streaming: dout_ready=1, din=0x01..0x0A on consecutive cycles -> dout 0x01..0x0A back-to-back, 0x01 valid 3 cycles after acceptance.
REQ-030 SHALL cover fill/stall: dout_ready=0, push 0x11,0x22,0x33,0x44 -> first three accepted, din_ready=0 on 0x44, dout=0x11 stable; count=3 if enabled.
REQ-031 SHALL cover full pass-through: from the full state, dout_ready=1 and din_valid=1 with 0x44 -> 0x11 out and 0x44 in same cycle, din_ready=1.
REQ-032 SHALL cover bubbles: din_valid alternating 1/0 with 0xA0,0xA1,0xA2, dout_ready toggling -> output order 0xA0,0xA1,0xA2, no loss.
REQ-033 SHALL cover reset mid-operation: rst=1 for one cycle with 2 words in flight -> next cycle dout_valid=0, dout=0, din_ready=1, count=0; old words never appear.

Source files
------------

// File: rtl/elastic_delay.sv
// elastic_delay: DELAY-stage valid/ready pipeline whose bubbles collapse under backpressure.
// Define ELASTIC_DELAY_COUNT_EN to add the registered occupancy output count.
module elastic_delay #(
  parameter int WIDTH = 1,
  parameter int DELAY = 1
) (
`ifdef ELASTIC_DELAY_COUNT_EN
  output logic [$clog2(DELAY+1)-1:0] count,
`endif
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [WIDTH-1:0] din,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [WIDTH-1:0] dout
);
  logic [DELAY-1:0] valid_q, valid_d, acc, vin;
  logic [WIDTH-1:0] data_q [DELAY];
  logic [WIDTH-1:0] data_d [DELAY];
  logic [WIDTH-1:0] din_c  [DELAY];
  // A stage accepts when the consumer takes a word or any stage between it and the output is empty.
  for (genvar g = 0; g < DELAY; g++) begin : g_acc
    assign acc[g] = dout_ready || !(&valid_q[DELAY-1:g]);
  end
  always_comb begin
    vin      = '0;
    vin[0]   = din_valid;
    din_c[0] = din;
    for (int k = 1; k < DELAY; k++) begin
      vin[k]   = valid_q[k-1];
      din_c[k] = data_q[k-1];
    end
    for (int k = 0; k < DELAY; k++) begin
      valid_d[k] = acc[k] ? vin[k] : valid_q[k];
      data_d[k]  = acc[k] && vin[k] ? din_c[k] : data_q[k];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign din_ready  = acc[0];
  assign dout_valid = valid_q[DELAY-1];
  assign dout       = data_q[DELAY-1];
`ifdef ELASTIC_DELAY_COUNT_EN
  localparam int CW = $clog2(DELAY+1);
  logic          in_fire, out_fire;
  logic [CW-1:0] count_q, count_d;
  assign in_fire  = din_valid && acc[0];
  assign out_fire = valid_q[DELAY-1] && dout_ready;
  assign count_d  = in_fire && !out_fire ? count_q + CW'(1) :
                    out_fire && !in_fire ? count_q - CW'(1) : count_q;
  always_ff @(posedge clk) count_q <= rst ? '0 : count_d;
  assign count = count_q;
`endif
endmodule
